// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the BCD counter family.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_MIN  = 4'd0;
  localparam int         MAX_DIGITS = 8;

  // A nibble is a legal BCD digit when it does not exceed 9.
  function automatic logic bcd_valid(input bcd_digit_t d);
    bcd_valid = (d <= BCD_MAX) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the cascade counter. Steps up or down by one when
// told to by the top-level chain, loads a pre-validated digit, and reports
// whether it currently sits at 9 or 0 so the chain can ripple the carry.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up_dn,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_r;
  bcd_digit_t digit_nxt_s;

  // Next digit value; never forms an intermediate above 9.
  always_comb begin
    digit_nxt_s = digit_r;
    if (up_dn) begin
      if (digit_r >= BCD_MAX) begin
        digit_nxt_s = BCD_MIN;
      end else begin
        digit_nxt_s = digit_r + 4'd1;
      end
    end else begin
      if (digit_r == BCD_MIN) begin
        digit_nxt_s = BCD_MAX;
      end else begin
        digit_nxt_s = digit_r - 4'd1;
      end
    end
  end

  // Digit register: reset beats load, load beats step, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_r <= BCD_MIN;
    end else if (ld) begin
      digit_r <= ld_val;
    end else if (step) begin
      digit_r <= digit_nxt_s;
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit  = digit_r;
  assign at_max = (digit_r == BCD_MAX) ? 1'b1 : 1'b0;
  assign at_min = (digit_r == BCD_MIN) ? 1'b1 : 1'b0;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit packed-BCD up/down counter with validated parallel load and a
// combinational terminal count for cascading.
// Optional build macro: BCD_CASCADE_COUNTER_SATURATE_EN -- when defined the
// counter holds at all-9s (up) or all-0s (down) instead of wrapping.
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    load_err
);

  bcd_digit_t            digit_s  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] at_max_s;
  logic [NUM_DIGITS-1:0] at_min_s;
  logic [NUM_DIGITS-1:0] valid_s;
  logic [NUM_DIGITS-1:0] step_s;
  logic                  all_max_s;
  logic                  all_min_s;
  logic                  load_ok_s;
  logic                  terminal_s;
  logic                  sat_block_s;
  logic                  en_step_s;
  logic                  load_err_r;

  // Per-digit BCD validity of the load word; any bad nibble rejects it whole.
  always_comb begin
    valid_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      valid_s[i] = bcd_valid(load_val[4*i +: 4]);
    end
  end

  assign all_max_s  = &at_max_s;
  assign all_min_s  = &at_min_s;
  assign load_ok_s  = load & (&valid_s);
  assign terminal_s = (up_dn & all_max_s) | (~up_dn & all_min_s);

  // Saturation gating: in the saturating build the last value is sticky.
  always_comb begin
`ifdef BCD_CASCADE_COUNTER_SATURATE_EN
    sat_block_s = terminal_s;
`else
    sat_block_s = 1'b0;
`endif
  end

  // A step happens only on an enabled cycle that is neither reset nor load
  // (a rejected load still suppresses stepping).
  assign en_step_s = en & ~load & ~rst & ~sat_block_s;

  // Step-enable ripple: digit i moves when every lower digit is at its
  // wrap point for the current direction.
  always_comb begin
    logic acc_s;
    step_s = '0;
    acc_s  = en_step_s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_s[i] = acc_s;
      acc_s     = acc_s & (up_dn ? at_max_s[i] : at_min_s[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .step   (step_s[g]),
        .up_dn  (up_dn),
        .ld     (load_ok_s),
        .ld_val (load_val[4*g +: 4]),
        .digit  (digit_s[g]),
        .at_max (at_max_s[g]),
        .at_min (at_min_s[g])
      );
      assign count[4*g +: 4] = digit_s[g];
    end
  endgenerate

  // Rejected-load flag: one-cycle pulse following a load with a bad nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_r <= 1'b0;
    end else if (load && !load_ok_s) begin
      load_err_r <= 1'b1;
    end else begin
      load_err_r <= 1'b0;
    end
  end

  assign load_err = load_err_r;
  assign tc       = en & ~load & ~rst & terminal_s;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed self-checking bench for bcd_cascade_counter (NUM_DIGITS = 2).
module tb_bcd_cascade_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       load_err;

  int total;
  int bad;

  bcd_cascade_counter #(.NUM_DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    to_bcd = {hi, lo};
  endfunction

  initial begin
    logic [7:0] down_exp [7];
    logic [7:0] exp_v;
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;

    // 1: reset for two cycles, then release with en low
    tick();
    chk("rst1_count", count, 8'h00);
    chk("rst1_err", {7'd0, load_err}, 8'h00);
    tick();
    chk("rst2_count", count, 8'h00);
    chk("rst2_err", {7'd0, load_err}, 8'h00);
    rst = 1'b0;
    tick();
    chk("hold_count", count, 8'h00);
    chk("hold_tc", {7'd0, tc}, 8'h00);
    tick();
    chk("hold2_count", count, 8'h00);

    // 2: count up 100 steps from 0
    en = 1'b1; up_dn = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("up_count_%0d", i), count, to_bcd(i));
      chk($sformatf("up_tc_%0d", i), {7'd0, tc}, (i == 99) ? 8'h01 : 8'h00);
      tick();
    end
`ifdef BCD_CASCADE_COUNTER_SATURATE_EN
    chk("up_wrap", count, 8'h99);
`else
    chk("up_wrap", count, 8'h00);
`endif

    // 3: load 0x05, count down 7 steps
    en = 1'b0; load = 1'b1; load_val = 8'h05;
    #1;
    chk("ld_tc", {7'd0, tc}, 8'h00);
    tick();
    chk("ld05_count", count, 8'h05);
    chk("ld05_err", {7'd0, load_err}, 8'h00);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
`ifdef BCD_CASCADE_COUNTER_SATURATE_EN
    down_exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
`else
    down_exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
`endif
    #1;
    for (int i = 0; i < 7; i++) begin
      exp_v = (count == 8'h00) ? 8'h01 : 8'h00;
      if (i < 5) begin
        chk($sformatf("dn_tc_%0d", i), {7'd0, tc}, 8'h00);
      end else begin
`ifdef BCD_CASCADE_COUNTER_SATURATE_EN
        chk($sformatf("dn_tc_%0d", i), {7'd0, tc}, 8'h01);
`else
        chk($sformatf("dn_tc_%0d", i), {7'd0, tc}, (i == 5) ? 8'h01 : 8'h00);
`endif
      end
      tick();
      chk($sformatf("dn_count_%0d", i), count, down_exp[i]);
    end

    // 4: invalid loads (high nibble and low nibble) while at 0x37
    en = 1'b0; load = 1'b1; load_val = 8'h37;
    tick();
    chk("ld37_count", count, 8'h37);
    load_val = 8'h4A;
    tick();
    chk("bad4A_count", count, 8'h37);
    chk("bad4A_err", {7'd0, load_err}, 8'h01);
    load = 1'b0;
    tick();
    chk("bad4A_count2", count, 8'h37);
    chk("bad4A_err_clear", {7'd0, load_err}, 8'h00);
    load = 1'b1; load_val = 8'hB2;
    tick();
    chk("badB2_count", count, 8'h37);
    chk("badB2_err", {7'd0, load_err}, 8'h01);
    load = 1'b0;
    tick();
    chk("badB2_err_clear", {7'd0, load_err}, 8'h00);

    // 5: load and enable on the same edge
    load = 1'b1; load_val = 8'h42; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("ld42_count", count, 8'h42);
    chk("ld42_err", {7'd0, load_err}, 8'h00);
    load = 1'b0;
    tick();
    chk("ld42_step", count, 8'h43);

    // 5b: cross-digit carry down 0x40 -> 0x39, and up 0x39 -> 0x40
    load = 1'b1; load_val = 8'h40; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("borrow_40", count, 8'h39);
    up_dn = 1'b1;
    tick();
    chk("carry_39", count, 8'h40);

    // 6: reset mid-count with load (bad value) and enable high
    load = 1'b1; load_val = 8'h58; en = 1'b0;
    tick();
    chk("ld58_count", count, 8'h58);
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h4A;
    #1;
    chk("rst_tc", {7'd0, tc}, 8'h00);
    tick();
    chk("rst_mid_count", count, 8'h00);
    chk("rst_mid_err", {7'd0, load_err}, 8'h00);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    chk("post_rst_count", count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_cascade_counter.md
# bcd_cascade_counter

Parametrised multi-digit BCD counter and the successor to the single-digit decade counter. It counts up or down in packed BCD across `NUM_DIGITS` decimal digits and supports enable, synchronous parallel load with BCD validation, and a combinational terminal-count output for cascading. It sits in the lab's counter/timer layer and drives display decoders and event tallies.

## Interface
- `NUM_DIGITS`, default 2: number of BCD digits; legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset; highest priority.
- `en` in 1: count enable; one step per cycle while high.
- `up_dn` in 1: direction; 1 counts up, 0 counts down; sampled only on enabled cycles.
- `load` in 1: synchronous parallel load request.
- `load_val` in 4*NUM_DIGITS: packed BCD load value; digit 0 sits in bits [3:0].
- `count` out 4*NUM_DIGITS: packed BCD count, registered.
- `tc` out 1: terminal count, combinational, for cascading.
- `load_err` out 1: registered, one-cycle pulse flagging a rejected load.

## Operation
- Reset values: `count` = 0 (all digits 0) and `load_err` = 0. `tc` follows its equation after reset.
- Per-cycle priority: `rst` > `load` > `en` > hold.
- Load, valid case: every nibble of `load_val` is ≤ 9. Then `count` takes `load_val` and `load_err` = 0.
- Load, invalid case: any nibble is ≥ 0xA. Then `count` holds, `load_err` = 1 for exactly that next cycle, and the rest of the word is not partially loaded.
- `load_err` is 0 on every cycle that is not a rejected load.
- Count up, per digit: the digit increments when all lower digits are 9; a digit at 9 goes to 0. The whole value steps from 10^N-1 to 0.
- Count down, per digit: the digit decrements when all lower digits are 0; a digit at 0 goes to 9. The whole value steps from 0 to 10^N-1.
- Digit values stay in 0..9 at all times. No binary intermediate exceeds 9 and no binary-to-BCD conversion is used.
- `tc` = `en` & ~`load` & ~`rst` & ((`up_dn` & all digits 9) | (~`up_dn` & all digits 0)).
- Direction change takes effect on the first enabled edge after it. There is no extra latency.
- Hold when `en` = 0: `count` is stable and `tc` = 0.

## Timing
- Load-to-output latency: 1 cycle. `load_val` is sampled at edge k and appears on `count` after edge k.
- Count latency: 1 cycle per step. `en` high for M consecutive edges advances `count` by exactly M (mod 10^N).
- `tc` is valid in the same cycle as the terminal value, before the wrapping edge. A downstream counter's `en` can tie directly to this `tc`.
- `rst` asserted mid-count: `count` = 0 after that edge regardless of `load` or `en`, and `load_err` = 0.
- `rst` and `load` together: reset wins.
- `load` and `en` together: load wins and no step occurs.

## Configuration
- Macro `BCD_CASCADE_COUNTER_SATURATE_EN`.
- Defined: counting up at all-9s holds at all-9s, and counting down at all-0s holds at all-0s. `tc` still asserts under its usual condition.
- Not defined (default): the counter wraps as described in Operation.
- Load, reset and `load_err` behaviour are identical in both builds.

## Structure
- Package `bcd_pkg` holds:
  - `typedef logic [3:0] bcd_digit_t`
  - `localparam bcd_digit_t BCD_MAX = 4'd9`
  - function `bcd_valid(bcd_digit_t)`, which returns 1 when the digit is ≤ 9.
- Sub-module `bcd_digit_cell`, one instance per digit via generate.
  - Inputs: `clk`, `rst`, `step`, `up_dn`, `ld`, `ld_val`.
  - Outputs: `digit`, `at_max`, `at_min`.
- The top level holds:
  - the step-enable chain (step[i] = enabled step & all lower digits at_max when up, or at_min when down);
  - load validation;
  - the `load_err` register;
  - `tc`;
  - saturation gating.

## Test plan
1. `rst`=1 for 2 cycles, then 0 with `en`=0 → `count`=0x00 and `load_err`=0 on both cycles; `count` holds at 0x00 after release.
2. `NUM_DIGITS`=2, `en`=1, `up_dn`=1 from 0 for 100 cycles → `count` steps 0x00..0x99 with no nibble above 9. `tc`=1 only while `count`=0x99, and `count`=0x00 after the 100th edge (with the saturate macro, stays 0x99).
3. Load 0x05, then `en`=1, `up_dn`=0 for 7 cycles → `count` = 0x04, 0x03, 0x02, 0x01, 0x00, 0x99, 0x98. `tc`=1 only while at 0x00.
4. `load`=1 with `load_val`=0x4A while `count`=0x37 → `count` stays 0x37, and `load_err`=1 for exactly one cycle.
5. `load`=1 with `load_val`=0x42 and `en`=1 on the same edge → `count`=0x42 with no step. On the next edge with `en`=1, `up_dn`=1 → `count`=0x43.
6. Reset mid-count at 0x58 with `en`=1 and `load`=1 → `count`=0x00 after the edge, and `load_err`=0.
